// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 register file with exception/eret handling and a Count/Compare timer
module cp0_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_cp0_rst,
    input  logic        cpu_cp0_mfc0,
    input  logic        cpu_cp0_mtc0,
    input  logic [31:0] cpu_cp0_pc,
    input  logic [4:0]  cpu_cp0_rd,
    input  logic [31:0] cpu_cp0_wdata,
    input  logic        cpu_cp0_exception,
    input  logic        cpu_cp0_eret,
    input  logic [4:0]  cpu_cp0_cause,
    output logic [31:0] cp0_cpu_rdata,
    output logic [31:0] cp0_cpu_status,
    output logic [31:0] cp0_cpu_exc_addr,
    output logic        cp0_cpu_timer_irq
);
    logic [31:0] count, compare, status, epc, cause;
    logic [4:0]  exc_code;
    logic        pending;
    logic        wr, timer_hit;

    assign wr        = cpu_cp0_mtc0 & ~cpu_cp0_exception & ~cpu_cp0_eret;
    assign timer_hit = (count == compare) && (compare != 32'd0);
    assign cause     = {16'd0, pending, 8'd0, exc_code, 2'b00};

    // register updates: exception beats eret beats mtc0; the timer runs regardless
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 32'd0;
            compare  <= 32'd0;
            status   <= 32'd0;
            epc      <= 32'd0;
            exc_code <= 5'd0;
            pending  <= 1'b0;
        end else if (cpu_cp0_rst) begin
            count    <= 32'd0;
            compare  <= 32'd0;
            status   <= 32'd0;
            epc      <= 32'd0;
            exc_code <= 5'd0;
            pending  <= 1'b0;
        end else begin
            count    <= (wr && cpu_cp0_rd == 5'd9) ? cpu_cp0_wdata : count + 32'd1;
            compare  <= (wr && cpu_cp0_rd == 5'd11) ? cpu_cp0_wdata : compare;
            status   <= cpu_cp0_exception ? status << 5 :
                        cpu_cp0_eret ? status >> 5 :
                        (wr && cpu_cp0_rd == 5'd12) ? cpu_cp0_wdata : status;
            epc      <= cpu_cp0_exception ? cpu_cp0_pc :
                        (wr && cpu_cp0_rd == 5'd14) ? cpu_cp0_wdata : epc;
            exc_code <= cpu_cp0_exception ? cpu_cp0_cause :
                        (wr && cpu_cp0_rd == 5'd13) ? cpu_cp0_wdata[6:2] : exc_code;
            pending  <= (wr && cpu_cp0_rd == 5'd11) ? 1'b0 :
                        timer_hit ? 1'b1 :
                        (wr && cpu_cp0_rd == 5'd13) ? cpu_cp0_wdata[15] : pending;
        end
    end

    // read mux and next-PC target from current state
    always_comb begin
        cp0_cpu_rdata = 32'd0;
        if (cpu_cp0_mfc0)
            cp0_cpu_rdata = (cpu_cp0_rd == 5'd9)  ? count :
                            (cpu_cp0_rd == 5'd11) ? compare :
                            (cpu_cp0_rd == 5'd12) ? status :
                            (cpu_cp0_rd == 5'd13) ? cause :
                            (cpu_cp0_rd == 5'd14) ? epc : 32'd0;
        cp0_cpu_exc_addr  = (cpu_cp0_eret && !cpu_cp0_exception) ? epc : EXC_VECTOR;
        cp0_cpu_status    = status;
        cp0_cpu_timer_irq = pending & status[15] & status[0];
    end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed self-checking bench for cp0_unit
module tb_cp0_unit;
    localparam logic [31:0] VEC = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        reset, cpu_cp0_rst, cpu_cp0_mfc0, cpu_cp0_mtc0;
    logic [31:0] cpu_cp0_pc, cpu_cp0_wdata;
    logic [4:0]  cpu_cp0_rd, cpu_cp0_cause;
    logic        cpu_cp0_exception, cpu_cp0_eret;
    logic [31:0] cp0_cpu_rdata, cp0_cpu_status, cp0_cpu_exc_addr;
    logic        cp0_cpu_timer_irq;
    int          checks = 0;
    int          errors = 0;

    cp0_unit #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .reset(reset), .cpu_cp0_rst(cpu_cp0_rst),
        .cpu_cp0_mfc0(cpu_cp0_mfc0), .cpu_cp0_mtc0(cpu_cp0_mtc0),
        .cpu_cp0_pc(cpu_cp0_pc), .cpu_cp0_rd(cpu_cp0_rd), .cpu_cp0_wdata(cpu_cp0_wdata),
        .cpu_cp0_exception(cpu_cp0_exception), .cpu_cp0_eret(cpu_cp0_eret),
        .cpu_cp0_cause(cpu_cp0_cause), .cp0_cpu_rdata(cp0_cpu_rdata),
        .cp0_cpu_status(cp0_cpu_status), .cp0_cpu_exc_addr(cp0_cpu_exc_addr),
        .cp0_cpu_timer_irq(cp0_cpu_timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] r, input logic [31:0] exp);
        cpu_cp0_mfc0 = 1'b1;
        cpu_cp0_rd   = r;
        #1;
        chk(tag, cp0_cpu_rdata, exp);
        cpu_cp0_mfc0 = 1'b0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        cpu_cp0_mtc0  = 1'b1;
        cpu_cp0_rd    = r;
        cpu_cp0_wdata = d;
        tick();
        cpu_cp0_mtc0  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cpu_cp0_rst = 1'b0; cpu_cp0_mfc0 = 1'b0; cpu_cp0_mtc0 = 1'b0;
        cpu_cp0_pc = 32'd0; cpu_cp0_wdata = 32'd0; cpu_cp0_rd = 5'd0; cpu_cp0_cause = 5'd0;
        cpu_cp0_exception = 1'b0; cpu_cp0_eret = 1'b0;
        #2;
        chk("reset_status", cp0_cpu_status, 32'd0);
        chk("reset_exc_addr", cp0_cpu_exc_addr, VEC);
        chk("reset_irq", {31'd0, cp0_cpu_timer_irq}, 32'd0);
        tick();
        reset = 1'b1;
        rd_chk("count_0", 5'd9, 32'd0);
        tick();
        rd_chk("count_1", 5'd9, 32'd1);
        tick();
        rd_chk("count_2", 5'd9, 32'd2);
        tick();

        wr(5'd12, 32'h0000_000F);
        rd_chk("status_read", 5'd12, 32'h0000_000F);
        chk("status_port", cp0_cpu_status, 32'h0000_000F);
        cpu_cp0_rd = 5'd12;
        #1;
        chk("rdata_no_mfc0", cp0_cpu_rdata, 32'd0);
        tick();
        wr(5'd5, 32'h1234_5678);
        rd_chk("unmapped_rd5", 5'd5, 32'd0);
        tick();

        reset = 1'b0;
        #1;
        chk("async_status", cp0_cpu_status, 32'd0);
        chk("async_exc_addr", cp0_cpu_exc_addr, VEC);
        rd_chk("async_count", 5'd9, 32'd0);
        tick();
        reset = 1'b1;
        wr(5'd12, 32'h0000_000F);

        cpu_cp0_exception = 1'b1; cpu_cp0_pc = 32'h0040_0120; cpu_cp0_cause = 5'd8;
        #1;
        chk("exc_addr_vector", cp0_cpu_exc_addr, VEC);
        tick();
        cpu_cp0_exception = 1'b0;
        chk("exc_status", cp0_cpu_status, 32'h0000_01E0);
        rd_chk("exc_epc", 5'd14, 32'h0040_0120);
        rd_chk("exc_cause", 5'd13, 32'h0000_0020);
        tick();

        cpu_cp0_eret = 1'b1;
        #1;
        chk("eret_exc_addr", cp0_cpu_exc_addr, 32'h0040_0120);
        tick();
        cpu_cp0_eret = 1'b0;
        chk("eret_status", cp0_cpu_status, 32'h0000_000F);
        rd_chk("eret_epc_kept", 5'd14, 32'h0040_0120);
        rd_chk("eret_cause_kept", 5'd13, 32'h0000_0020);
        tick();

        cpu_cp0_exception = 1'b1; cpu_cp0_eret = 1'b1; cpu_cp0_mtc0 = 1'b1;
        cpu_cp0_rd = 5'd12; cpu_cp0_wdata = 32'h0000_ABCD;
        cpu_cp0_pc = 32'h0040_0200; cpu_cp0_cause = 5'd9;
        #1;
        chk("all_exc_addr", cp0_cpu_exc_addr, VEC);
        tick();
        cpu_cp0_exception = 1'b0; cpu_cp0_eret = 1'b0; cpu_cp0_mtc0 = 1'b0;
        chk("all_status", cp0_cpu_status, 32'h0000_01E0);
        rd_chk("all_epc", 5'd14, 32'h0040_0200);
        rd_chk("all_cause", 5'd13, 32'h0000_0024);
        tick();

        cpu_cp0_rst = 1'b1;
        tick();
        cpu_cp0_rst = 1'b0;
        chk("soft_status", cp0_cpu_status, 32'd0);
        rd_chk("soft_epc", 5'd14, 32'd0);
        rd_chk("soft_cause", 5'd13, 32'd0);
        rd_chk("soft_count", 5'd9, 32'd0);
        tick();

        wr(5'd11, 32'd20);
        wr(5'd12, 32'h0000_8001);
        wr(5'd9, 32'd0);
        cpu_cp0_mfc0 = 1'b1;
        cpu_cp0_rd = 5'd9;
        repeat (20) tick();
        chk("timer_count20", cp0_cpu_rdata, 32'd20);
        chk("timer_irq_pre", {31'd0, cp0_cpu_timer_irq}, 32'd0);
        tick();
        cpu_cp0_mfc0 = 1'b0;
        chk("timer_irq_set", {31'd0, cp0_cpu_timer_irq}, 32'd1);
        rd_chk("timer_cause_set", 5'd13, 32'h0000_8000);
        tick();
        wr(5'd11, 32'd100);
        chk("timer_irq_clr", {31'd0, cp0_cpu_timer_irq}, 32'd0);
        rd_chk("timer_cause_clr", 5'd13, 32'd0);
        tick();

        wr(5'd9, 32'hFFFF_FFFF);
        rd_chk("wrap_max", 5'd9, 32'hFFFF_FFFF);
        tick();
        rd_chk("wrap_zero", 5'd9, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
